// File: rtl/led_arbiter_if.sv
// Request/colour/brightness bundle from the status sources and the grant/LED drive back out.
// master = request side, slave = arbiter.
interface led_arbiter_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic [2:0]          REQ;
  logic [8:0]          REQ_COLOR;
  logic [2:0]          REQ_BLINK;
  logic [PWM_BITS-1:0] BRIGHTNESS;
  logic [2:0]          GRANT;
  logic                LED_RED;
  logic                LED_BLUE;
  logic                LED_GREEN;

  modport master (
    output REQ, REQ_COLOR, REQ_BLINK, BRIGHTNESS,
    input  GRANT, LED_RED, LED_BLUE, LED_GREEN
  );

  modport slave (
    input  REQ, REQ_COLOR, REQ_BLINK, BRIGHTNESS,
    output GRANT, LED_RED, LED_BLUE, LED_GREEN
  );
endinterface

// File: rtl/led_arbiter.sv
// Fixed-priority (bit 0 wins) RGB LED arbiter with minimum hold, blink and global PWM brightness.
// GRANT one cycle after REQ, LEDs one cycle after GRANT; release is never held off by MIN_HOLD.
module led_arbiter #(
  parameter longint unsigned TICK_DIV = 64'd6250000,
  parameter int unsigned     MIN_HOLD = 4,
  parameter int unsigned     PWM_BITS = 8
) (
  input  logic          SYSCLK,
  input  logic          RESET_N,
  led_arbiter_if.slave  bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = (MIN_HOLD == 0) ? 1 : $clog2(MIN_HOLD + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 64'd1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MIN_HOLD == 0) ? 0 : MIN_HOLD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;
  localparam state_t ARM = (MIN_HOLD == 0) ? OPEN : HOLD;

  state_t              state;
  logic [2:0]          grant;
  logic [TW-1:0]       tick_cnt;
  logic [HW-1:0]       hold_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                phase;
  logic                led_red, led_blue, led_green;

  logic [2:0] req;
  logic [2:0] first_req;
  logic [2:0] higher;
  logic [2:0] color;
  logic       blink;
  logic       tick, pwm_on, lit, released, restart;

  assign req       = bus.REQ;
  assign first_req = req & (~req + 3'd1);
  // Only meaningful while something is granted: requests of higher priority than the grant.
  assign higher    = req & (grant - 3'd1);
  assign tick      = (tick_cnt == TICK_LAST);
  assign pwm_on    = (pwm_cnt < bus.BRIGHTNESS);
  assign lit       = pwm_on & (phase | ~blink);
  assign released  = (state != IDLE) && ((req & grant) == 3'b000);
  assign restart   = (|req) && ((state == IDLE) || released || (state == OPEN && |higher));

  always_comb begin
    color = 3'b000;
    blink = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        color = bus.REQ_COLOR[3*i +: 3];
        blink = bus.REQ_BLINK[i];
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      grant     <= 3'b000;
      tick_cnt  <= '0;
      hold_cnt  <= '0;
      pwm_cnt   <= '0;
      phase     <= 1'b1;
      led_red   <= 1'b0;
      led_blue  <= 1'b0;
      led_green <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) phase <= ~phase;
      led_red   <= color[0] & lit;
      led_blue  <= color[1] & lit;
      led_green <= color[2] & lit;

      // A new grant restarts the blink period so it always begins lit.
      if (restart) begin
        grant    <= first_req;
        state    <= ARM;
        tick_cnt <= '0;
        hold_cnt <= '0;
        phase    <= 1'b1;
      end else if (released) begin
        grant <= 3'b000;
        state <= IDLE;
      end else if (state == HOLD && tick) begin
        if (hold_cnt == HOLD_LAST) state <= OPEN;
        else                       hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign bus.GRANT     = grant;
  assign bus.LED_RED   = led_red;
  assign bus.LED_BLUE  = led_blue;
  assign bus.LED_GREEN = led_green;
endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares the board's single RGB status LED between three requesters, e.g. boot status, error and activity blocks.
- Each requester asks for a colour, optionally blinking. A fixed-priority arbiter with a minimum-hold time picks the winner.
- A global PWM stage scales brightness.
- Sits between status sources and the LED_RED/LED_BLUE/LED_GREEN pins at top level.

Parameters:
- TICK_DIV, default 6250000: SYSCLK cycles per blink tick (0.25 s at 25 MHz); valid range 2..2^32.
- MIN_HOLD, default 4: blink ticks a new grant is held before it can be preempted; 0 means preemptible immediately.
- PWM_BITS, default 8: width of the PWM counter and of BRIGHTNESS.

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- REQ  in  3  request per requester; bit 0 highest priority, bit 2 lowest.
- REQ_COLOR  in  9  colour per requester; bits [3i+2:3i] = {G,B,R} for requester i.
- REQ_BLINK  in  3  blink enable per requester.
- BRIGHTNESS  in  PWM_BITS  global duty; 0 = off, all-ones = (2^PWM_BITS-1)/2^PWM_BITS.
- GRANT  out  3  one-hot grant, registered; 0 when idle.
- LED_RED  out  1  red drive, registered.
- LED_BLUE  out  1  blue drive, registered.
- LED_GREEN  out  1  green drive, registered.

Behaviour:
- Reset (RESET_N=0 at a clock edge):
  - state=IDLE, GRANT=0, all LEDs=0.
  - tick counter=0, hold counter=0, PWM counter=0, blink phase=1 (on).
  - Reset mid-grant drops the grant in that same edge.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - Internal tick pulses one cycle when the count equals TICK_DIV-1.
  - Blink phase toggles on each tick.
- Grant restart: every new grant (from IDLE, re-arbitration or preemption) clears the tick counter and hold counter and sets the blink phase to 1. A blinking grant therefore always starts lit for a full tick period.
- PWM: PWM_BITS-bit free-running counter; pwm_on = (pwm_cnt < BRIGHTNESS), unsigned compare.
- FSM states: IDLE, HOLD, OPEN. "Highest pending" = lowest-index set bit of REQ.
- IDLE:
  - If REQ != 0, register GRANT = one-hot of highest pending.
  - Go to HOLD, or to OPEN if MIN_HOLD=0.
- HOLD:
  - The hold counter increments on each tick.
  - Go to OPEN on the tick where hold count reaches MIN_HOLD-1.
  - Higher-priority requests are ignored in HOLD.
- OPEN: a higher-priority REQ bit set → GRANT switches to it and the FSM re-enters HOLD (hold counter 0). Lower-priority requests never preempt.
- Granted REQ bit drops (HOLD or OPEN):
  - Re-arbitrate the same cycle: GRANT = highest other pending, HOLD entered.
  - If none pending, GRANT=0 and the FSM goes to IDLE.
  - Release is never delayed by MIN_HOLD.
- Simultaneous events: if the granted bit drops on the same cycle a higher bit rises, the result is one re-arbitration to the highest pending; no extra idle cycle.
- LED output:
  - Each LED = granted colour bit AND pwm_on AND (phase OR NOT granted blink).
  - Registered from the registered GRANT.
  - REQ_COLOR and REQ_BLINK of the granted requester are sampled live every cycle, not latched at grant.
  - GRANT=0 → all LEDs 0.
- Latency:
  - REQ rises at edge n in IDLE → GRANT valid after edge n+1.
  - LEDs reflect it after edge n+2.
  - Release has the same 1/2-cycle latency.
- Width rules:
  - Tick counter is ceil(log2(TICK_DIV)) bits; hold counter is ceil(log2(MIN_HOLD+1)) bits.
  - No counter overflows across its range.

Test Plan (TICK_DIV=4, MIN_HOLD=2, PWM_BITS=8 unless stated):
- Reset/idle: hold RESET_N=0 for 3 cycles, REQ=000 → GRANT=000 and LEDs=000 throughout; after release, still 000 for 20 cycles.
- Single steady grant: REQ=010, colour1=101, BLINK=0, BRIGHTNESS=255 → GRANT=010 one cycle later; LED_RED=LED_GREEN=1 for 255 of every 256 cycles; LED_BLUE=0.
- Blink timing: REQ=001, colour0=001, BLINK=1, BRIGHTNESS=255 (PWM_BITS=2 for visibility) → LED_RED lit 4 cycles from grant, dark 4, lit 4, gated by PWM (0 only when pwm_cnt=3).
- Minimum hold:
  - REQ=100 granted at cycle 0; REQ bit 0 set at cycle 2 → GRANT stays 100 until the hold expires (2 ticks = 8 cycles), then GRANT=001 the next cycle.
  - With MIN_HOLD=0 → switch one cycle after REQ bit 0 rises.
- Release and simultaneous events:
  - Granted requester 0 drops REQ while REQ=110 → GRANT=010 the next cycle, no idle cycle.
  - Granted bit drops on the same cycle bit 0 rises → GRANT=001.
  - All drop → GRANT=000, then LEDs 000 one cycle later.
- Reset mid-operation / brightness 0: BRIGHTNESS=0 with an active grant → LEDs constantly 0; assert RESET_N=0 mid-grant → GRANT=000 after that edge; on release, re-grant starts with blink phase on.
